// File: rtl/uc_fsm_pkg.sv
// Shared state encodings, opcode[5:2] constants and the decoded-control record
// used by the two-cycle sequential control unit.
package uc_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LI   = 4'b0000;
  localparam logic [3:0] OP_NOP  = 4'b0001;
  localparam logic [3:0] OP_HALT = 4'b0011;
  localparam logic [3:0] OP_J    = 4'b0100;
  localparam logic [3:0] OP_JZ   = 4'b0101;
  localparam logic [3:0] OP_JNZ  = 4'b0110;

  // opcode[5] set selects the ALU class; opcode[4:2] is then the ALU operation
  localparam int ALU_BIT = 5;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic       halt;
    logic       undef;
  } ctrl_t;

  // Control values driven whenever the FSM is not executing
  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                                  op_alu: 3'b000, halt: 1'b0, undef: 1'b0};

endpackage

// File: rtl/uc_fsm_instr_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Holds at all-ones once reached; never wraps.
module instr_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/uc_fsm.sv
// Two-cycle (FETCH, EXEC) control unit for the single-cycle datapath with
// run/halt/single-step control, a sticky illegal-opcode flag and a retired count.
module uc_fsm
  import uc_fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             z,
  input  logic [5:0]       opcode,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;
  logic   exec;
  logic   unused_opnd;

  // opcode[1:0] belong to operand fields and never affect decode
  assign unused_opnd = &{1'b0, opcode[1:0]};

  always_comb begin
    dec = CTRL_IDLE;
    if (opcode[ALU_BIT]) begin
      dec.op_alu = opcode[4:2];
      dec.we3    = 1'b1;
      dec.wez    = 1'b1;
    end else begin
      case (opcode[5:2])
        OP_LI: begin
          dec.we3   = 1'b1;
          dec.s_inm = 1'b1;
        end
        OP_J:    dec.s_inc = 1'b0;
        OP_JZ:   dec.s_inc = ~z;
        OP_JNZ:  dec.s_inc = z;
        OP_NOP:  dec.s_inc = 1'b1;
        OP_HALT: dec.halt  = 1'b1;
        default: dec.undef = 1'b1;
      endcase
    end
  end

  // Gating on the async-reset state register drops the controls as soon as reset hits
  assign exec = (state == EXEC);
  assign ctrl = exec ? dec : CTRL_IDLE;

  assign s_inc  = ctrl.s_inc;
  assign s_inm  = ctrl.s_inm;
  assign we3    = ctrl.we3;
  assign wez    = ctrl.wez;
  assign op_alu = ctrl.op_alu;
  assign pc_we  = exec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          state <= EXEC;
        end
        EXEC: begin
          if (dec.undef) illegal <= 1'b1;
          // HALT takes priority over single-step
          if (dec.halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (step) begin
            state <= IDLE;
          end else begin
            state <= FETCH;
          end
        end
        HALT: begin
          if (start) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  instr_counter #(
    .WIDTH(CNT_W)
  ) u_instr_counter (
    .clk  (clk),
    .clr_n(reset),
    .en   (exec),
    .count(instr_count)
  );

endmodule

// File: tb/tb_uc_fsm.sv
// Bench for uc_fsm: decode table in single-step mode, HALT/resume, free-running
// burst with counter saturation, illegal opcode and asynchronous reset mid-EXEC.
module tb_uc_fsm;

  logic        clk = 1'b0;
  logic        reset, start, step, z;
  logic [5:0]  opcode;

  logic        s_inc, s_inm, we3, wez, pc_we, halted, illegal;
  logic [2:0]  op_alu;
  logic [15:0] instr_count;

  logic        s_inc4, s_inm4, we3_4, wez4, pc_we4, halted4, illegal4;
  logic [2:0]  op_alu4;
  logic [3:0]  instr_count4;

  uc_fsm #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .z(z), .opcode(opcode),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op_alu(op_alu),
    .pc_we(pc_we), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  uc_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .step(step), .z(z), .opcode(opcode),
    .s_inc(s_inc4), .s_inm(s_inm4), .we3(we3_4), .wez(wez4), .op_alu(op_alu4),
    .pc_we(pc_we4), .halted(halted4), .illegal(illegal4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e_inc;
    logic       e_inm;
    logic       e_we3;
    logic       e_wez;
    logic [2:0] e_alu;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       zz;
    logic       e_inc;
    logic       e_inm;
    logic       e_we3;
    logic       e_wez;
    logic [2:0] e_alu;
    logic       e_halt;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cnt   = 0;
  logic exp_ill = 1'b0;
  exp_t sbq[$];
  vec_t tbl[11];

  localparam exp_t NOP_EXP = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
  localparam exp_t LI_EXP  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
  localparam logic [7:0] IDLE_CTRL = 8'b0000_1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_count16"}, 32'(instr_count), 32'(cnt));
    chk({nm, "_count4"}, 32'(instr_count4), (cnt > 15) ? 32'd15 : 32'(cnt));
    chk({nm, "_illegal"}, 32'(illegal), 32'(exp_ill));
  endtask

  // Every EXEC (pc_we high) must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (pc_we === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_exec", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("exec_s_inc", 32'(s_inc), 32'(e.e_inc));
        chk("exec_s_inm", 32'(s_inm), 32'(e.e_inm));
        chk("exec_we3", 32'(we3), 32'(e.e_we3));
        chk("exec_wez", 32'(wez), 32'(e.e_wez));
        chk("exec_op_alu", 32'(op_alu), 32'(e.e_alu));
        chk("exec_halted", 32'(halted), 32'd0);
        chk("exec_dut4_ctrl", 32'({pc_we4, we3_4, wez4, s_inm4, s_inc4, op_alu4}),
            32'({1'b1, e.e_we3, e.e_wez, e.e_inm, e.e_inc, e.e_alu}));
      end
    end
  end

  // One instruction in single-step mode, entered from IDLE or HALT just after a posedge
  task automatic run_step(input logic [5:0] op, input logic zz, input exp_t e,
                          input logic exp_halt);
    opcode = op;
    z      = zz;
    step   = 1'b1;
    start  = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("fetch_ctrl", 32'({pc_we, we3, wez, s_inm, s_inc, op_alu}), 32'(IDLE_CTRL));
    @(posedge clk);
    @(posedge clk);
    cnt++;
    @(negedge clk);
    chk("post_exec_pc_we", 32'(pc_we), 32'd0);
    chk("post_exec_halted", 32'(halted), 32'(exp_halt));
    chk_counts("post_exec");
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; step = 1'b0; z = 1'b0; opcode = 6'b0;

    tbl[0]  = '{6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[1]  = '{6'b101000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0};
    tbl[2]  = '{6'b111111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0};
    tbl[3]  = '{6'b010100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[4]  = '{6'b010100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[5]  = '{6'b011000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[6]  = '{6'b011000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[7]  = '{6'b010011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[8]  = '{6'b000111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[9]  = '{6'b001100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
    tbl[10] = '{6'b100001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({pc_we, we3, wez, s_inm, s_inc, op_alu}), 32'(IDLE_CTRL));
    chk("reset_halted", 32'(halted), 32'd0);
    chk_counts("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start_pc_we", 32'(pc_we), 32'd0);

    // Decode table, one single-stepped instruction per entry (entry 9 also shows HALT beats step)
    for (int i = 0; i < 11; i++) begin
      run_step(tbl[i].op, tbl[i].zz,
               '{tbl[i].e_inc, tbl[i].e_inm, tbl[i].e_we3, tbl[i].e_wez, tbl[i].e_alu},
               tbl[i].e_halt);
    end

    // HALT while free-running: PC advances once, then the FSM parks in HALT
    opcode = 6'b001100; step = 1'b0; start = 1'b1;
    sbq.push_back(NOP_EXP);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    cnt++;
    @(negedge clk);
    chk("halt_entered", 32'(halted), 32'd1);
    chk("halt_pc_we", 32'(pc_we), 32'd0);
    chk_counts("halt");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_hold", 32'({halted, pc_we}), 32'b10);
    @(posedge clk);
    #1;
    opcode = 6'b000100; step = 1'b1; start = 1'b1;
    sbq.push_back(NOP_EXP);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("resume_fetch", 32'({halted, pc_we, we3}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    cnt++;
    @(negedge clk);
    chk("resume_idle", 32'({halted, pc_we}), 32'd0);
    chk_counts("resume");
    @(posedge clk);
    #1;

    // 20 free-running instructions with start held high; single-step stops the burst
    opcode = 6'b000101; step = 1'b0; start = 1'b1;
    repeat (20) sbq.push_back(NOP_EXP);
    @(posedge clk);
    repeat (39) @(posedge clk);
    #1 step = 1'b1; start = 1'b0;
    @(posedge clk);
    cnt += 20;
    @(negedge clk);
    chk("burst_pc_we", 32'(pc_we), 32'd0);
    chk("burst_sat4", 32'(instr_count4), 32'hF);
    chk_counts("burst");
    repeat (2) @(posedge clk);
    #1;

    // Undefined opcode runs as NOP and latches illegal
    exp_ill = 1'b1;
    run_step(6'b011100, 1'b0, NOP_EXP, 1'b0);
    run_step(6'b000000, 1'b0, LI_EXP, 1'b0);

    // Asynchronous reset in the middle of an EXEC that writes the register file
    opcode = 6'b000000; step = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_reset_we3", 32'(we3), 32'd1);
    reset = 1'b0;
    #1;
    cnt = 0;
    exp_ill = 1'b0;
    chk("midexec_reset_ctrl", 32'({pc_we, we3, wez, s_inm, s_inc, op_alu}), 32'(IDLE_CTRL));
    chk("midexec_reset_halted", 32'(halted), 32'd0);
    chk_counts("midexec_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    run_step(6'b000000, 1'b0, LI_EXP, 1'b0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
